// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: queues fetch-time BTB predictions, checks them at execute,
// drives the BTB write port and raises a timed flush with a redirect PC on a mispredict.
//
// state | meaning
// RUN   | normal operation, queue accepts pushes/pops, resolution active
// FLUSH | flush asserted, fetch/execute inputs ignored, counter runs down
module branch_resolver #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pf_valid,
    input  logic [31:0]      pf_pc,
    input  logic             pf_hit,
    input  logic [31:0]      pf_target,
    output logic             pq_full,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             br_update,
    output logic [31:0]      pc_ex,
    output logic [31:0]      target_pc,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             desync,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispred
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {RUN, FLUSH} state_t;
    state_t state, state_nx;

    logic [31:0]   q_pc  [DEPTH];
    logic          q_hit [DEPTH];
    logic [31:0]   q_tgt [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [2:0]    fcnt;

    logic          empty, full, taken;
    logic [31:0]   h_pc, h_tgt, redirect_nx;
    logic          h_hit;
    logic          do_pop, do_push, q_take, mispredict, upd_en, desync_set;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign pq_full = full;
    assign flush   = (state == FLUSH);
    assign taken   = ex_is_branch & ex_taken;
    assign q_take  = do_pop & ~empty;

    // An empty queue presents a synthetic not-hit record matching ex_pc
    assign h_pc  = empty ? ex_pc : q_pc[rd_ptr];
    assign h_hit = ~empty & q_hit[rd_ptr];
    assign h_tgt = q_tgt[rd_ptr];

    always_comb begin
        state_nx    = state;
        do_pop      = 1'b0;
        do_push     = 1'b0;
        mispredict  = 1'b0;
        upd_en      = 1'b0;
        desync_set  = 1'b0;
        redirect_nx = redirect_pc;
        if (state == RUN) begin
            do_pop  = ex_valid;
            do_push = pf_valid & (~full | ex_valid);
            if (pf_valid & full & ~ex_valid)
                desync_set = 1'b1;
            if (ex_valid) begin
                if (empty)
                    desync_set = 1'b1;
                if (taken && (!h_hit || h_tgt != ex_target)) begin
                    mispredict  = 1'b1;
                    redirect_nx = ex_target;
                    upd_en      = (ex_pc[1:0] == 2'b00);
                end else if (h_hit && !taken) begin
                    mispredict  = 1'b1;
                    redirect_nx = ex_pc + 32'd4;
                end
                if (h_pc != ex_pc) begin
                    desync_set = 1'b1;
                    if (!mispredict) begin
                        mispredict  = 1'b1;
                        redirect_nx = ex_pc + 32'd4;
                    end
                end
            end
            if (mispredict)
                state_nx = FLUSH;
        end else begin
            if (fcnt == 3'd1)
                state_nx = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            br_update   <= 1'b0;
            pc_ex       <= '0;
            target_pc   <= '0;
            redirect_pc <= '0;
            desync      <= 1'b0;
            cnt_branch  <= '0;
            cnt_mispred <= '0;
            fcnt        <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state       <= state_nx;
            br_update   <= upd_en;
            redirect_pc <= redirect_nx;
            if (upd_en) begin
                pc_ex     <= ex_pc;
                target_pc <= ex_target;
            end
            if (desync_set)
                desync <= 1'b1;
            if (do_pop && ex_is_branch && cnt_branch != '1)
                cnt_branch <= cnt_branch + CNT_W'(1);
            if (mispredict) begin
                if (cnt_mispred != '1)
                    cnt_mispred <= cnt_mispred + CNT_W'(1);
                fcnt   <= 3'(FLUSH_CYCLES);
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (state == FLUSH)
                    fcnt <= fcnt - 3'd1;
                if (do_push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (q_take)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + (PW+1)'(do_push) - (PW+1)'(q_take);
            end
        end
    end

    // Queue storage needs no reset: entries are only read once pushed
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_pc[wr_ptr]  <= pf_pc;
            q_hit[wr_ptr] <= pf_hit;
            q_tgt[wr_ptr] <= pf_target;
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: a behavioural model predicts every output
// after each clock and a scoreboard queue carries those predictions to the compare point.
module tb_branch_resolver;
    localparam int DEPTH = 4;
    localparam int FC    = 2;
    localparam int CW    = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pf_valid = 0, pf_hit = 0, ex_valid = 0, ex_is_branch = 0, ex_taken = 0;
    logic [31:0] pf_pc = 0, pf_target = 0, ex_pc = 0, ex_target = 0;
    logic pq_full, br_update, flush, desync;
    logic [31:0] pc_ex, target_pc, redirect_pc;
    logic [CW-1:0] cnt_branch, cnt_mispred;

    branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .pf_valid(pf_valid), .pf_pc(pf_pc), .pf_hit(pf_hit), .pf_target(pf_target),
        .pq_full(pq_full),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .br_update(br_update), .pc_ex(pc_ex), .target_pc(target_pc),
        .flush(flush), .redirect_pc(redirect_pc), .desync(desync),
        .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        upd;
        logic [31:0] pcex;
        logic [31:0] tgt;
        logic        fl;
        logic [31:0] redir;
        logic        ds;
        logic [15:0] cb;
        logic [15:0] cm;
        logic        full;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] mq_pc[$], mq_tgt[$];
    logic        mq_hit[$];
    int          m_left;
    logic [31:0] m_pcex, m_tgt, m_redir;
    logic        m_ds;
    logic [15:0] m_cb, m_cm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        mq_pc.delete(); mq_tgt.delete(); mq_hit.delete();
        m_left = 0; m_pcex = 0; m_tgt = 0; m_redir = 0; m_ds = 0; m_cb = 0; m_cm = 0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, predict, push expectation, clock, pop and compare
    task automatic cyc(input logic pv, input logic [31:0] ppc, input logic phit, input logic [31:0] ptgt,
                       input logic ev, input logic [31:0] epc, input logic ebr, input logic etk,
                       input logic [31:0] etgt);
        exp_t e;
        logic mis, upd, hhit, tk;
        logic [31:0] hpc, htgt;
        pf_valid = pv; pf_pc = ppc; pf_hit = phit; pf_target = ptgt;
        ex_valid = ev; ex_pc = epc; ex_is_branch = ebr; ex_taken = etk; ex_target = etgt;
        mis = 0; upd = 0;
        if (m_left > 0) begin
            m_left--;
        end else begin
            if (ev) begin
                if (mq_pc.size() == 0) begin
                    hpc = epc; hhit = 0; htgt = 0; m_ds = 1;
                end else begin
                    hpc = mq_pc.pop_front(); hhit = mq_hit.pop_front(); htgt = mq_tgt.pop_front();
                end
                tk = ebr & etk;
                if (ebr && m_cb != 16'hFFFF) m_cb++;
                if (tk && (!hhit || htgt != etgt)) begin
                    mis = 1; m_redir = etgt;
                    if (epc[1:0] == 2'b00) begin upd = 1; m_pcex = epc; m_tgt = etgt; end
                end else if (hhit && !tk) begin
                    mis = 1; m_redir = epc + 32'd4;
                end
                if (hpc != epc) begin
                    m_ds = 1;
                    if (!mis) begin mis = 1; m_redir = epc + 32'd4; end
                end
            end
            if (pv) begin
                if (mq_pc.size() < DEPTH) begin
                    mq_pc.push_back(ppc); mq_hit.push_back(phit); mq_tgt.push_back(ptgt);
                end else m_ds = 1;
            end
            if (mis) begin
                mq_pc.delete(); mq_hit.delete(); mq_tgt.delete();
                m_left = FC;
                if (m_cm != 16'hFFFF) m_cm++;
            end
        end
        e.upd = upd; e.pcex = m_pcex; e.tgt = m_tgt; e.fl = (m_left > 0); e.redir = m_redir;
        e.ds = m_ds; e.cb = m_cb; e.cm = m_cm; e.full = (mq_pc.size() == DEPTH);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("br_update", 32'(br_update), 32'(e.upd));
        check("pc_ex", pc_ex, e.pcex);
        check("target_pc", target_pc, e.tgt);
        check("flush", 32'(flush), 32'(e.fl));
        check("redirect_pc", redirect_pc, e.redir);
        check("desync", 32'(desync), 32'(e.ds));
        check("cnt_branch", 32'(cnt_branch), 32'(e.cb));
        check("cnt_mispred", 32'(cnt_mispred), 32'(e.cm));
        check("pq_full", 32'(pq_full), 32'(e.full));
    endtask

    task automatic push(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
        cyc(1, pc, hit, tgt, 0, 0, 0, 0, 0);
    endtask

    task automatic exec(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
        cyc(0, 0, 0, 0, 1, pc, br, tk, tgt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_br_update"}, 32'(br_update), 0);
        check({tag, "_pc_ex"}, pc_ex, 0);
        check({tag, "_target_pc"}, target_pc, 0);
        check({tag, "_flush"}, 32'(flush), 0);
        check({tag, "_redirect_pc"}, redirect_pc, 0);
        check({tag, "_desync"}, 32'(desync), 0);
        check({tag, "_cnt_branch"}, 32'(cnt_branch), 0);
        check({tag, "_cnt_mispred"}, 32'(cnt_mispred), 0);
        check({tag, "_pq_full"}, 32'(pq_full), 0);
    endtask

    initial begin
        model_reset();
        #22;
        check_reset_values("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // predict-correct taken
        push(32'h100, 1, 32'h200);
        exec(32'h100, 1, 1, 32'h200);
        // cold miss, flush with a push arriving during flush (ignored)
        push(32'h104, 0, 0);
        exec(32'h104, 1, 1, 32'h300);
        cyc(1, 32'h1F0, 1, 32'h1F4, 0, 0, 0, 0, 0);
        idle(2);
        // false hit on a non-branch
        push(32'h108, 1, 32'h400);
        exec(32'h108, 0, 0, 0);
        idle(3);
        // full queue, push+pop when full, then overflow push
        for (int i = 0; i < DEPTH; i++) push(32'h200 + 32'(4*i), 0, 0);
        cyc(1, 32'h210, 0, 0, 1, 32'h200, 0, 0, 0);
        push(32'h214, 0, 0);
        for (int i = 1; i <= DEPTH; i++) exec(32'h200 + 32'(4*i), 0, 0, 0);
        // misaligned taken mispredict: flush without BTB update
        push(32'h102, 0, 0);
        exec(32'h102, 1, 1, 32'h500);
        idle(3);
        // push and pop together on empty queue
        cyc(1, 32'h120, 1, 32'h600, 1, 32'h11C, 0, 0, 0);
        exec(32'h120, 1, 1, 32'h600);
        // mispredict discards a simultaneous push
        push(32'h130, 0, 0);
        cyc(1, 32'h134, 1, 32'h134, 1, 32'h130, 1, 1, 32'h700);
        idle(3);
        push(32'h140, 1, 32'h800);
        exec(32'h140, 1, 1, 32'h800);
        // head PC mismatch
        push(32'h150, 0, 0);
        exec(32'h154, 0, 0, 0);
        idle(3);
        // reset during the first flush cycle
        push(32'h160, 0, 0);
        exec(32'h160, 1, 1, 32'h900);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midflush");
        model_reset();
        pf_valid = 0; ex_valid = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(32'h170, 1, 32'hA00);
        exec(32'h170, 1, 1, 32'hA00);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
